// File: rtl/frame_buffer_writer.sv
// Drains the pixel CDC FIFO into DDR through the MIG write handshake, placing
// successive frames into a ring of frame buffers; locked buffers are skipped.
module frame_buffer_writer #(
  parameter int ADDR_W         = 29,
  parameter int CNT_W          = 9,
  parameter int BURST_LEN      = 1,
  parameter int ADDR_INCREMENT = 8,
  parameter int NUM_BUFFERS    = 4,
  parameter int RESET_CYCLES   = 4,
  parameter int FLUSH_ON_END   = 1,
  localparam int IDX_W         = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                   mem_clk,
  input  logic                   mem_reset,
  input  logic                   frame_valid,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      buf_stride,
  input  logic [19:0]            max_bursts,
  input  logic [NUM_BUFFERS-1:0] buf_lock,
  input  logic [CNT_W-1:0]       fifo_rd_data_count,
  input  logic                   fifo_empty,
  input  logic                   fifo_rst_busy,
  output logic                   fifo_reset,
  output logic                   discard_rd_en,
  output logic                   mem_wr_req,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  input  logic                   mem_wr_ack,
  output logic                   ready,
  output logic                   frame_written,
  output logic [IDX_W-1:0]       written_buf,
  output logic [19:0]            written_bursts,
  output logic                   frame_skipped,
  output logic                   truncated,
  output logic [2:0]             dbg_state
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BURST_WORDS = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(ADDR_INCREMENT);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_BUFFERS - 1);

  // MIG handshake: mem_wr_req is a registered level that rises the cycle after
  // WRITE_REQ qualifies and holds, with mem_wr_addr stable, until the cycle in
  // which mem_wr_ack is sampled high; it is low the cycle after that ack.
  typedef enum logic [2:0] {
    S_RESET_FIFO = 3'd0,
    S_IDLE       = 3'd1,
    S_WRITE_REQ  = 3'd2,
    S_WRITE_ACK  = 3'd3,
    S_FLUSH_REQ  = 3'd4,
    S_FLUSH_ACK  = 3'd5,
    S_DISCARD    = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic              fv_meta_q, fv_s_q, fv_prev_q;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic              fifo_reset_q, fifo_reset_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [19:0]       burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0]  sel_idx_q, sel_idx_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              discard_q, discard_d;
  logic              trunc_path_q, trunc_path_d;
  logic              written_q, written_d;
  logic [IDX_W-1:0]  written_buf_q, written_buf_d;
  logic [19:0]       written_bursts_q, written_bursts_d;
  logic              skipped_q, skipped_d;
  logic              truncated_q, truncated_d;

  logic              fv_rise;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              hit_limit;

  assign fv_rise   = fv_s_q & ~fv_prev_q;
  assign hit_limit = (max_bursts != 20'd0) && ((burst_cnt_q + 20'd1) == max_bursts);

  // Cyclic search from wr_ptr: iterate from the far end so the nearest free
  // buffer is the last one assigned.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_BUFFERS - 1; k >= 0; k--) begin
      if (!buf_lock[IDX_W'((int'(wr_ptr_q) + k) % NUM_BUFFERS)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(wr_ptr_q) + k) % NUM_BUFFERS);
      end
    end
  end

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      fv_meta_q <= 1'b0;
      fv_s_q    <= 1'b0;
      fv_prev_q <= 1'b0;
    end else begin
      fv_meta_q <= frame_valid;
      fv_s_q    <= fv_meta_q;
      fv_prev_q <= fv_s_q;
    end
  end

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state_q          <= S_RESET_FIFO;
      rst_cnt_q        <= '0;
      fifo_reset_q     <= 1'b1;
      req_q            <= 1'b0;
      addr_q           <= '0;
      burst_cnt_q      <= '0;
      sel_idx_q        <= '0;
      wr_ptr_q         <= '0;
      discard_q        <= 1'b0;
      trunc_path_q     <= 1'b0;
      written_q        <= 1'b0;
      written_buf_q    <= '0;
      written_bursts_q <= '0;
      skipped_q        <= 1'b0;
      truncated_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      rst_cnt_q        <= rst_cnt_d;
      fifo_reset_q     <= fifo_reset_d;
      req_q            <= req_d;
      addr_q           <= addr_d;
      burst_cnt_q      <= burst_cnt_d;
      sel_idx_q        <= sel_idx_d;
      wr_ptr_q         <= wr_ptr_d;
      discard_q        <= discard_d;
      trunc_path_q     <= trunc_path_d;
      written_q        <= written_d;
      written_buf_q    <= written_buf_d;
      written_bursts_q <= written_bursts_d;
      skipped_q        <= skipped_d;
      truncated_q      <= truncated_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    rst_cnt_d        = rst_cnt_q;
    fifo_reset_d     = fifo_reset_q;
    req_d            = req_q;
    addr_d           = addr_q;
    burst_cnt_d      = burst_cnt_q;
    sel_idx_d        = sel_idx_q;
    wr_ptr_d         = wr_ptr_q;
    discard_d        = 1'b0;
    trunc_path_d     = trunc_path_q;
    written_d        = 1'b0;
    written_buf_d    = written_buf_q;
    written_bursts_d = written_bursts_q;
    skipped_d        = 1'b0;
    truncated_d      = 1'b0;

    case (state_q)
      S_RESET_FIFO: begin
        if (fifo_reset_q) begin
          if (rst_cnt_q == RC_LAST) fifo_reset_d = 1'b0;
          else                      rst_cnt_d    = rst_cnt_q + 1'b1;
        end else if (!fifo_rst_busy) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (fv_rise) begin
          sel_idx_d    = sel_idx;
          trunc_path_d = 1'b0;
          if (sel_found) begin
            addr_d      = base_addr + (buf_stride * ADDR_W'(sel_idx));
            burst_cnt_d = '0;
            state_d     = S_WRITE_REQ;
          end else begin
            skipped_d = 1'b1;
            state_d   = S_DISCARD;
          end
        end
      end

      S_WRITE_REQ: begin
        // A stale ack still high from the previous burst must not qualify.
        if ((fifo_rd_data_count >= BURST_WORDS) && !mem_wr_ack) begin
          req_d   = 1'b1;
          state_d = S_WRITE_ACK;
        end else if (!fv_s_q && fifo_empty) begin
          state_d = (FLUSH_ON_END != 0) ? S_FLUSH_REQ : S_DONE;
        end
      end

      S_WRITE_ACK: begin
        if (mem_wr_ack) begin
          req_d       = 1'b0;
          addr_d      = addr_q + ADDR_STEP;
          burst_cnt_d = burst_cnt_q + 20'd1;
          if (hit_limit) begin
            truncated_d  = 1'b1;
            trunc_path_d = 1'b1;
            state_d      = S_DISCARD;
          end else begin
            state_d = S_WRITE_REQ;
          end
        end
      end

      S_FLUSH_REQ: begin
        req_d   = 1'b1;
        state_d = S_FLUSH_ACK;
      end

      S_FLUSH_ACK: begin
        if (mem_wr_ack) begin
          req_d   = 1'b0;
          addr_d  = addr_q + ADDR_STEP;
          state_d = S_DONE;
        end
      end

      S_DISCARD: begin
        discard_d = !fifo_empty;
        if (!fv_s_q && fifo_empty) begin
          if (trunc_path_q) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_RESET_FIFO;
            fifo_reset_d = 1'b1;
            rst_cnt_d    = '0;
          end
        end
      end

      S_DONE: begin
        written_d        = 1'b1;
        written_buf_d    = sel_idx_q;
        written_bursts_d = burst_cnt_q;
        wr_ptr_d         = (sel_idx_q == LAST_IDX) ? '0 : sel_idx_q + 1'b1;
        state_d          = S_RESET_FIFO;
        fifo_reset_d     = 1'b1;
        rst_cnt_d        = '0;
      end

      default: state_d = S_RESET_FIFO;
    endcase
  end

  assign fifo_reset     = fifo_reset_q;
  assign discard_rd_en  = discard_q;
  assign mem_wr_req     = req_q;
  assign mem_wr_addr    = addr_q;
  assign ready          = (state_q == S_IDLE);
  assign frame_written  = written_q;
  assign written_buf    = written_buf_q;
  assign written_bursts = written_bursts_q;
  assign frame_skipped  = skipped_q;
  assign truncated      = truncated_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: a FIFO/MIG model answers the DUT,
// and a scoreboard checks burst addresses and per-frame results.
module tb_frame_buffer_writer;

  localparam int ADDR_W = 29;
  localparam int CNT_W  = 9;
  localparam int BL     = 1;

  logic              mem_clk;
  logic              mem_reset;
  logic              frame_valid;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] buf_stride;
  logic [19:0]       max_bursts;
  logic [3:0]        buf_lock;
  logic [CNT_W-1:0]  fifo_rd_data_count;
  logic              fifo_empty;
  logic              fifo_rst_busy;
  logic              fifo_reset;
  logic              discard_rd_en;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic              mem_wr_ack;
  logic              ready;
  logic              frame_written;
  logic [1:0]        written_buf;
  logic [19:0]       written_bursts;
  logic              frame_skipped;
  logic              truncated;
  logic [2:0]        dbg_state;

  frame_buffer_writer dut (
    .mem_clk(mem_clk), .mem_reset(mem_reset), .frame_valid(frame_valid),
    .base_addr(base_addr), .buf_stride(buf_stride), .max_bursts(max_bursts),
    .buf_lock(buf_lock), .fifo_rd_data_count(fifo_rd_data_count),
    .fifo_empty(fifo_empty), .fifo_rst_busy(fifo_rst_busy),
    .fifo_reset(fifo_reset), .discard_rd_en(discard_rd_en),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_ack(mem_wr_ack),
    .ready(ready), .frame_written(frame_written), .written_buf(written_buf),
    .written_bursts(written_bursts), .frame_skipped(frame_skipped),
    .truncated(truncated), .dbg_state(dbg_state)
  );

  // clock / reset
  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [1:0]        exp_buf_q[$];
  logic [19:0]       exp_bursts_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // environment model state
  int fifo_cnt     = 0;
  int busy_cnt     = 0;
  int pushed_total = 0;
  int pushed_seen  = 0;
  int ack_delay    = 0;
  int ack_wait     = 0;
  int acks         = 0;
  int discard_pops = 0;
  int fr_rises     = 0;
  int req_cycles   = 0;
  int wr_pulses    = 0;
  int skip_pulses  = 0;
  int trunc_pulses = 0;
  logic fr_prev    = 1'b0;

  assign fifo_rd_data_count = CNT_W'(fifo_cnt);
  assign fifo_empty         = (fifo_cnt == 0);
  assign fifo_rst_busy      = (busy_cnt > 0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO, reset-busy and MIG ack model plus output monitors, all on the negedge.
  initial begin
    mem_wr_ack = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (fifo_reset) begin
        fifo_cnt = 0;
        busy_cnt = 3;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      fifo_cnt   += pushed_total - pushed_seen;
      pushed_seen = pushed_total;
      if (discard_rd_en && fifo_cnt > 0) begin
        fifo_cnt--;
        discard_pops++;
      end
      if (fifo_reset && !fr_prev) fr_rises++;
      fr_prev = fifo_reset;
      if (mem_wr_req) req_cycles++;
      if (frame_skipped) skip_pulses++;
      if (truncated) trunc_pulses++;
      if (frame_written) begin
        wr_pulses++;
        check("written_sb_nonempty", exp_buf_q.size() > 0, 1);
        if (exp_buf_q.size() > 0) begin
          check("written_buf", written_buf, exp_buf_q.pop_front());
          check("written_bursts", written_bursts, exp_bursts_q.pop_front());
        end
      end
      if (mem_reset) begin
        mem_wr_ack = 1'b0;
        ack_wait   = 0;
      end else if (mem_wr_ack) begin
        mem_wr_ack = 1'b0;
      end else if (mem_wr_req) begin
        if (ack_wait >= ack_delay) begin
          ack_wait   = 0;
          mem_wr_ack = 1'b1;
          acks++;
          check("addr_sb_nonempty", exp_addr_q.size() > 0, 1);
          if (exp_addr_q.size() > 0) check("burst_addr", mem_wr_addr, exp_addr_q.pop_front());
          fifo_cnt = (fifo_cnt > BL) ? fifo_cnt - BL : 0;
        end else begin
          ack_wait++;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 3000) begin
      @(negedge mem_clk);
      n++;
    end
    check(tag, ready, 1);
  endtask

  task automatic expect_frame(input int idx, input int nb, input bit flush);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(32'h1000 + idx * 32'h400);
    for (int b = 0; b < nb; b++) exp_addr_q.push_back(a + ADDR_W'(8 * b));
    if (flush) exp_addr_q.push_back(a + ADDR_W'(8 * nb));
    exp_buf_q.push_back(2'(idx));
    exp_bursts_q.push_back(20'(nb));
  endtask

  task automatic start_frame(input int nwords);
    wait_ready("ready_before_frame");
    frame_valid   = 1'b1;
    pushed_total += nwords;
  endtask

  task automatic end_frame(input int hold);
    repeat (hold) @(negedge mem_clk);
    frame_valid = 1'b0;
    wait_ready("ready_after_frame");
  endtask

  task automatic release_reset_check;
    int n = 0;
    mem_reset = 1'b0;
    while (fifo_reset && n < 20) begin
      n++;
      @(negedge mem_clk);
    end
    check("fifo_reset_cycles", n, 4);
  endtask

  // directed stimulus
  int a_acks, a_wr, a_skip, a_trunc, a_disc, a_fr, a_req, lat, nhi;
  logic [ADDR_W-1:0] a0;
  logic moved;

  initial begin
    mem_reset   = 1'b0;
    frame_valid = 1'b0;
    base_addr   = ADDR_W'(32'h1000);
    buf_stride  = ADDR_W'(32'h400);
    max_bursts  = 20'd0;
    buf_lock    = 4'b0000;
    #1 mem_reset = 1'b1;

    @(negedge mem_clk);
    check("rst_fifo_reset", fifo_reset, 1);
    check("rst_mem_wr_req", mem_wr_req, 0);
    check("rst_mem_wr_addr", mem_wr_addr, 0);
    check("rst_ready", ready, 0);
    check("rst_discard", discard_rd_en, 0);
    check("rst_frame_written", frame_written, 0);
    check("rst_written_buf", written_buf, 0);
    check("rst_written_bursts", written_bursts, 0);
    check("rst_skipped", frame_skipped, 0);
    check("rst_truncated", truncated, 0);
    repeat (2) @(negedge mem_clk);
    release_reset_check();
    wait_ready("ready_after_reset");

    // three full frames into consecutive buffers, each with a flush burst
    for (int f = 0; f < 3; f++) begin
      expect_frame(f, 10, 1'b1);
      a_acks = acks;
      start_frame(10);
      if (f == 0) begin
        lat = 0;
        while (!mem_wr_req && lat < 20) begin
          @(negedge mem_clk);
          lat++;
        end
        check("rise_to_req_latency", lat, 4);
      end
      end_frame(40);
      check("frame_ack_count", acks - a_acks, 11);
    end

    // walk wr_ptr to 1, then lock buffer 1 so the frame lands in buffer 2
    expect_frame(3, 2, 1'b1);
    start_frame(2);
    end_frame(10);
    expect_frame(0, 2, 1'b1);
    start_frame(2);
    end_frame(10);
    buf_lock = 4'b0010;
    expect_frame(2, 2, 1'b1);
    start_frame(2);
    end_frame(10);
    buf_lock = 4'b0000;
    expect_frame(3, 2, 1'b1);
    start_frame(2);
    end_frame(10);

    // every buffer locked: the frame is discarded
    buf_lock = 4'b1111;
    a_acks = acks; a_wr = wr_pulses; a_skip = skip_pulses; a_disc = discard_pops;
    a_fr = fr_rises; a_req = req_cycles;
    start_frame(20);
    end_frame(40);
    check("skip_pulses", skip_pulses - a_skip, 1);
    check("skip_discarded", discard_pops - a_disc, 20);
    check("skip_no_req", req_cycles - a_req, 0);
    check("skip_no_written", wr_pulses - a_wr, 0);
    check("skip_fifo_reset", fr_rises - a_fr, 1);
    buf_lock = 4'b0000;

    // burst limit: 12 words, 5 written, 7 discarded, no flush
    max_bursts = 20'd5;
    expect_frame(0, 5, 1'b0);
    a_acks = acks; a_wr = wr_pulses; a_trunc = trunc_pulses; a_disc = discard_pops;
    start_frame(12);
    end_frame(40);
    check("trunc_acks", acks - a_acks, 5);
    check("trunc_pulses", trunc_pulses - a_trunc, 1);
    check("trunc_discarded", discard_pops - a_disc, 7);
    check("trunc_written", wr_pulses - a_wr, 1);
    max_bursts = 20'd0;

    // slow ack: request and address hold until the ack
    ack_delay = 50;
    expect_frame(1, 2, 1'b1);
    start_frame(2);
    lat = 0;
    while (!mem_wr_req && lat < 50) begin
      @(negedge mem_clk);
      lat++;
    end
    check("slow_req_seen", mem_wr_req, 1);
    a0 = mem_wr_addr;
    nhi = 0;
    moved = 1'b0;
    while (mem_wr_req && nhi < 200) begin
      if (mem_wr_addr !== a0) moved = 1'b1;
      nhi++;
      @(negedge mem_clk);
    end
    check("slow_req_cycles", nhi, 51);
    check("slow_addr_stable", moved, 0);
    check("slow_addr_step", mem_wr_addr, a0 + ADDR_W'(8));
    end_frame(5);

    // reset in WRITE_ACK abandons the frame
    a_wr = wr_pulses;
    start_frame(3);
    lat = 0;
    while (!mem_wr_req && lat < 50) begin
      @(negedge mem_clk);
      lat++;
    end
    check("rst_mid_req_seen", mem_wr_req, 1);
    repeat (5) @(negedge mem_clk);
    mem_reset = 1'b1;
    #1;
    check("rst_mid_req_drop", mem_wr_req, 0);
    check("rst_mid_fifo_reset", fifo_reset, 1);
    frame_valid = 1'b0;
    repeat (3) @(negedge mem_clk);
    release_reset_check();
    wait_ready("ready_after_mid_reset");
    check("rst_mid_no_written", wr_pulses - a_wr, 0);
    ack_delay = 0;

    // wr_ptr back at 0 after reset
    expect_frame(0, 1, 1'b1);
    start_frame(1);
    end_frame(10);

    check("addr_sb_drained", exp_addr_q.size(), 0);
    check("frame_sb_drained", exp_buf_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Memory-clock-domain engine that drains a pixel CDC FIFO into DDR through the MIG write-request handshake, placing successive frames into a ring of NUM_BUFFERS frame buffers. It is the parametrised successor of the single-buffer camera write path: burst length, address step, buffer count and frame size limit are configurable. Buffers held by the host reader are skipped, and oversize frames are truncated rather than allowed to overrun the next buffer. It sits between the pixel FIFO's read side and the MIG user-interface arbiter.

## Interface
- ADDR_W, 29: MIG word address width.
- CNT_W, 9: FIFO read data count width.
- BURST_LEN, 1: FIFO words consumed per MIG write.
- ADDR_INCREMENT, 8: address step per burst.
- NUM_BUFFERS, 4: frame buffers in the ring (1..16).
- RESET_CYCLES, 4: FIFO reset assertion length.
- FLUSH_ON_END, 1: issue one extra burst at frame end.

Ports:
- mem_clk, in, 1: sole clock.
- mem_reset, in, 1: asynchronous, active-high reset.
- frame_valid, in, 1: pixel-domain level; double-flopped internally.
- base_addr, in, ADDR_W: address of buffer 0; sampled in IDLE.
- buf_stride, in, ADDR_W: spacing between buffers.
- max_bursts, in, 20: per-frame burst limit; 0 means unlimited.
- buf_lock, in, NUM_BUFFERS: bit k=1 means buffer k is held by the reader.
- fifo_rd_data_count, in, CNT_W.
- fifo_empty, in, 1.
- fifo_rst_busy, in, 1: OR of the FIFO's wr/rd reset-busy flags.
- fifo_reset, out, 1.
- discard_rd_en, out, 1: pops one FIFO word while discarding.
- mem_wr_req, out, 1.
- mem_wr_addr, out, ADDR_W.
- mem_wr_ack, in, 1.
- ready, out, 1: high in IDLE.
- frame_written, out, 1: one-cycle pulse.
- written_buf, out, clog2(NUM_BUFFERS) (minimum 1): buffer index of the last written frame.
- written_bursts, out, 20: bursts written in the last frame.
- frame_skipped, out, 1: one-cycle pulse.
- truncated, out, 1: one-cycle pulse.

## Operation
- fv_s is frame_valid after the 2-flop synchroniser. A rise is fv_s high with the previous sample low.
- **RESET_FIFO**: drives fifo_reset for RESET_CYCLES cycles, then waits for !fifo_rst_busy, then goes to IDLE. This is the state entered from reset.
- **IDLE**: ready=1.
  - On a rise, select buffer = first index, searching cyclically from wr_ptr, whose buf_lock bit is 0.
  - If a buffer is found: mem_wr_addr <= base_addr + idx*buf_stride, truncated to ADDR_W; burst_cnt <= 0; go to WRITE_REQ.
  - If all buffers are locked: pulse frame_skipped and go to DISCARD.
  - A frame already high when IDLE is entered is not captured; only a rise starts a capture.
- **WRITE_REQ**:
  - If fifo_rd_data_count >= BURST_LEN and !mem_wr_ack: assert mem_wr_req and go to WRITE_ACK.
  - Otherwise, if fv_s=0 and fifo_empty: go to FLUSH_REQ if FLUSH_ON_END, else DONE.
- **WRITE_ACK**: hold mem_wr_req until mem_wr_ack.
  - On ack: mem_wr_addr += ADDR_INCREMENT; burst_cnt += 1.
  - If max_bursts != 0 and burst_cnt+1 == max_bursts: pulse truncated and go to DISCARD.
  - Otherwise go to WRITE_REQ.
- **FLUSH_REQ / FLUSH_ACK**: one unconditional request/ack, with the same address increment as a normal burst. The flush burst does not increment burst_cnt. Then go to DONE.
- **DISCARD**: discard_rd_en = !fifo_empty, registered. Leave when fv_s=0 and fifo_empty.
  - After truncation: go to DONE.
  - After a skip: go to RESET_FIFO with no frame_written.
- **DONE** (1 cycle):
  - Pulse frame_written; written_buf <= selected idx; written_bursts <= burst_cnt.
  - wr_ptr <= idx+1, wrapping to 0 after NUM_BUFFERS-1.
  - Go to RESET_FIFO.
- buf_lock is sampled only at selection. A lock asserted mid-frame on the active buffer is ignored.
- Reset values of all outputs are 0, except fifo_reset=1. wr_ptr resets to 0.

## Timing
- Frame rise to first mem_wr_req: 2 sync cycles, +1 IDLE, +1 WRITE_REQ, provided the FIFO already holds BURST_LEN words.
- mem_wr_req is registered. It rises the cycle after WRITE_REQ qualifies and stays high through the ack cycle. It is low the cycle after ack.
- mem_wr_addr is stable while mem_wr_req=1. It changes the cycle after ack.
- Back-to-back bursts: minimum 3 cycles per burst (WRITE_REQ, request, ack).
- Asserting mem_reset mid-burst drops mem_wr_req asynchronously. The partial frame is abandoned with no frame_written, and the block restarts in RESET_FIFO.
- A ready ack in the same cycle as frame-end detection: the ack is processed first, and the end is seen on the next WRITE_REQ visit.

## Test plan
- NUM_BUFFERS=4, base=0x1000, stride=0x400, 3 frames of 10 bursts, no locks -> writes to 0x1000, 0x1400 and 0x1800 in sequence; written_buf = 0, 1, 2; written_bursts = 10 each; each frame has 11 acks (FLUSH_ON_END).
- buf_lock=4'b0010 with wr_ptr=1 -> frame goes to buffer 2 (address 0x1800); next wr_ptr=3.
- buf_lock=4'b1111, one frame of 20 FIFO words -> frame_skipped pulses once; discard_rd_en pulses 20 times; no mem_wr_req; FIFO reset afterwards.
- max_bursts=5, frame of 12 bursts -> exactly 5 acks; truncated pulses once; 7 words discarded; written_bursts=5; no flush burst.
- Ack held off 50 cycles -> mem_wr_req stays high with a constant address; the increment appears 1 cycle after ack.
- mem_reset asserted during WRITE_ACK -> mem_wr_req goes low immediately; fifo_reset is held for 4 cycles after release, then ready=1; no frame_written.
